// File: rtl/command_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : command_driver_pkg
// Description : Shared definitions for the driver -> DDR2-controller command
//               path: command codes, FSM states, address field offsets and
//               the block-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package command_driver_pkg;

    typedef logic [15:0] ulogic16;
    typedef logic [24:0] ulogic25;
    typedef logic [5:0]  ulogic6;

    // Command codes on the controller bus; code 7 is treated like NOP.
    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_SCALAR_RD = 3'd1,
        CMD_SCALAR_WR = 3'd2,
        CMD_BLK_RD    = 3'd3,
        CMD_BLK_WR    = 3'd4,
        CMD_ATOMIC_RD = 3'd5,
        CMD_ATOMIC_WR = 3'd6
    } cmd_e;

    localparam logic [2:0] CMD_NOP_ALT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_BLK_DATA = 2'd2
    } state_e;

    // Address layout {row, col_hi, bank, col_lo}
    localparam int ADDR_ROW_LSB    = 12;
    localparam int ADDR_COLHI_LSB  = 5;
    localparam int ADDR_BANK_LSB   = 3;
    localparam int ADDR_COLLO_LSB  = 0;

    localparam int BEAT_UNIT = 8;

    // Number of data beats in a block transfer for a given size code.
    function automatic ulogic6 beats_for(input logic [1:0] sz);
        return 6'(BEAT_UNIT * (32'(sz) + 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/command_driver_blk_beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : command_driver_blk_beat_counter
// Description : Down-counter for block-write data beats. Loads the beat
//               total, decrements once per consumed beat, flags the last one.
// Revision    : 1.0 - initial release
// ============================================================================
module command_driver_blk_beat_counter
    import command_driver_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic       dec,
    output logic       last
);

    ulogic6 count_q;
    ulogic6 count_d;

    // Load has priority; never decrement below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != 6'd0)) begin
            count_d = count_q - 6'd1;
        end
    end

    // Beat count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 6'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == 6'd1);

endmodule
`default_nettype wire

// File: rtl/command_driver.sv
`default_nettype none
// ============================================================================
// Module      : command_driver
// Description : Accepts transaction requests from the stimulus generator and
//               presents them on the DDR2-controller command bus, streaming
//               block-write beats while the controller is fetching.
// Revision    : 1.0 - initial release
// ============================================================================
module command_driver
    import command_driver_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DEBUG = 0
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             init_done,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_cmd,
    input  logic [1:0]       req_sz,
    input  logic [2:0]       req_op,
    input  logic [24:0]      req_addr,
    input  logic [15:0]      req_data,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [15:0]      wdata,
    input  logic             notfull,
    input  logic             fetching,
    output logic [2:0]       cmd,
    output logic [1:0]       sz,
    output logic [2:0]       op,
    output logic [24:0]      addr,
    output logic [15:0]      din,
    output logic             busy,
    output logic             underrun,
    output logic [CNT_W-1:0] cmd_count
);

    state_e           state_q, state_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [1:0]       sz_q, sz_d;
    logic [2:0]       op_q, op_d;
    ulogic25          addr_q, addr_d;
    ulogic16          din_q, din_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             underrun_q, underrun_d;
    logic             beat_load;
    logic             beat_dec;
    logic             beat_last;

    // Requests are taken only from IDLE once the controller is initialised and
    // has room; gating with reset_n keeps the handshake quiet during reset.
    assign req_ready = reset_n && (state_q == ST_IDLE) && init_done && notfull;

    // Next-state and output-register update for the 3-state issue FSM.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        sz_d       = sz_q;
        op_d       = op_q;
        addr_d     = addr_q;
        din_d      = din_q;
        count_d    = count_q;
        underrun_d = underrun_q;
        beat_load  = 1'b0;
        beat_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // NOP codes are consumed from the request stream but never issued.
                if (req_valid && req_ready &&
                    (req_cmd != CMD_NOP) && (req_cmd != CMD_NOP_ALT)) begin
                    cmd_d  = req_cmd;
                    sz_d   = req_sz;
                    op_d   = req_op;
                    addr_d = req_addr;
                    if ((req_cmd == CMD_SCALAR_WR) || (req_cmd == CMD_ATOMIC_RD) ||
                        (req_cmd == CMD_ATOMIC_WR)) begin
                        din_d = req_data;
                    end else begin
                        din_d = 16'd0;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The captured command is on the bus for exactly this cycle.
                count_d = count_q + 1'b1;
                cmd_d   = CMD_NOP;
                if (cmd_q == CMD_BLK_WR) begin
                    beat_load = 1'b1;
                    state_d   = ST_BLK_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BLK_DATA: begin
                // A fetch with no beat available still counts; it is flagged.
                if (fetching) begin
                    beat_dec = 1'b1;
                    if (!wdata_valid) begin
                        underrun_d = 1'b1;
                    end
                    if (beat_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= 3'd0;
            sz_q       <= 2'd0;
            op_q       <= 3'd0;
            addr_q     <= 25'd0;
            din_q      <= 16'd0;
            count_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            sz_q       <= sz_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            count_q    <= count_d;
            underrun_q <= underrun_d;
        end
    end

    command_driver_blk_beat_counter u_beat_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (beat_load),
        .load_val (beats_for(sz_q)),
        .dec      (beat_dec),
        .last     (beat_last)
    );

    // During block data the write beat passes straight through to the controller.
    assign din         = (state_q == ST_BLK_DATA) ? (wdata_valid ? wdata : 16'd0) : din_q;
    assign wdata_ready = reset_n && (state_q == ST_BLK_DATA) && fetching;
    assign cmd         = cmd_q;
    assign sz          = sz_q;
    assign op          = op_q;
    assign addr        = addr_q;
    assign busy        = (state_q != ST_IDLE);
    assign underrun    = underrun_q;
    assign cmd_count   = count_q;

    // Hook for simulation-only command tracing; carries no hardware.
    if (DEBUG != 0) begin : g_debug_hook
    end

endmodule
`default_nettype wire
